// File: rtl/nor_prealign.sv
// nor_prealign: input-side alignment stage for the FPU add/sub datapath.
// Unpacks two IEEE-754 singles, orders them by magnitude and right-shifts the
// smaller mantissa a few bits per cycle into the 28-bit normalizer format
// {carry, hidden, fraction[22:0], G, R, sticky}.
module nor_prealign #(
    parameter int unsigned SHIFT_STEP = 4,
    parameter int unsigned MAX_DIFF   = 27
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  logic        i_sub,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [7:0]  o_exp,
    output logic [27:0] o_mant_a,
    output logic [27:0] o_mant_b,
    output logic        o_sign_a,
    output logic        o_sign_b,
    output logic        o_aos_alu,
    output logic        o_swap,
    output logic        o_special
);

    localparam logic [7:0] STEP_W = 8'(SHIFT_STEP);
    localparam logic [7:0] MAX_W  = 8'(MAX_DIFF);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  exp_q;
    logic [27:0] mant_a_q;
    logic [27:0] mant_b_q;
    logic        sign_a_q;
    logic        sign_b_q;
    logic        aos_q;
    logic        swap_q;
    logic        special_q;
    logic        valid_q;
    logic [7:0]  rem_q;

    // Unpacked / ordered view of the incoming operand pair
    logic        sa, sb, sb_eff;
    logic [7:0]  ea, eb, eea, eeb;
    logic [22:0] fa, fb;
    logic [27:0] ma, mb;
    logic        swap_d, special_d, sgn_big_d, sgn_small_d;
    logic [27:0] big_m_d, small_m_d;
    logic [7:0]  big_e_d, diff_raw, diff_d;

    // Shift datapath for one ALIGN cycle
    logic [7:0]  step;
    logic [27:0] shift_mask;
    logic [27:0] shifted;
    logic        lost;

    // Operand unpack, magnitude ordering and clamped exponent difference
    always_comb begin
        sa     = i_op_a[31];
        ea     = i_op_a[30:23];
        fa     = i_op_a[22:0];
        sb     = i_op_b[31];
        eb     = i_op_b[30:23];
        fb     = i_op_b[22:0];
        sb_eff = sb ^ i_sub;

        ma  = {1'b0, |ea, fa, 3'b000};
        mb  = {1'b0, |eb, fb, 3'b000};
        eea = (ea == 8'd0) ? 8'd1 : ea;
        eeb = (eb == 8'd0) ? 8'd1 : eb;

        swap_d    = {eb, fb} > {ea, fa};
        special_d = (&ea) | (&eb);

        big_m_d     = ma;
        small_m_d   = mb;
        big_e_d     = ea;
        diff_raw    = eea - eeb;
        sgn_big_d   = sa;
        sgn_small_d = sb_eff;
        if (swap_d) begin
            big_m_d     = mb;
            small_m_d   = ma;
            big_e_d     = eb;
            diff_raw    = eeb - eea;
            sgn_big_d   = sb_eff;
            sgn_small_d = sa;
        end

        if (special_d)
            diff_d = 8'd0;
        else if (diff_raw >= MAX_W)
            diff_d = MAX_W;
        else
            diff_d = diff_raw;
    end

    // Per-cycle shift of the small mantissa; dropped bits fold into sticky
    always_comb begin
        step       = (rem_q < STEP_W) ? rem_q : STEP_W;
        shift_mask = ~({28{1'b1}} << step);
        shifted    = mant_b_q >> step;
        lost       = |(mant_b_q & shift_mask);
    end

    // Control FSM with registered result fields
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            exp_q     <= '0;
            mant_a_q  <= '0;
            mant_b_q  <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            aos_q     <= 1'b0;
            swap_q    <= 1'b0;
            special_q <= 1'b0;
            valid_q   <= 1'b0;
            rem_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        exp_q     <= big_e_d;
                        mant_a_q  <= big_m_d;
                        sign_a_q  <= sgn_big_d;
                        sign_b_q  <= sgn_small_d;
                        aos_q     <= sa ^ sb_eff;
                        swap_q    <= swap_d;
                        special_q <= special_d;
                        rem_q     <= diff_d;
                        if (diff_d == 8'd0) begin
                            mant_b_q <= small_m_d;
                            valid_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end else if (diff_d >= MAX_W) begin
                            mant_b_q <= {27'd0, |small_m_d};
                            valid_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            mant_b_q <= small_m_d;
                            state_q  <= S_ALIGN;
                        end
                    end
                end
                S_ALIGN: begin
                    mant_b_q <= {shifted[27:1], shifted[0] | lost};
                    rem_q    <= rem_q - step;
                    if (rem_q == step) begin
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ready   = (state_q == S_IDLE);
    assign o_valid   = valid_q;
    assign o_exp     = exp_q;
    assign o_mant_a  = mant_a_q;
    assign o_mant_b  = mant_b_q;
    assign o_sign_a  = sign_a_q;
    assign o_sign_b  = sign_b_q;
    assign o_aos_alu = aos_q;
    assign o_swap    = swap_q;
    assign o_special = special_q;

endmodule
